// File: rtl/rob_commit.sv
// In-order retirement buffer: entries are allocated in program order and completed
// by tag in any order. Done head entries are retired through the register file write port.
module rob_commit #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd_s,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [31:0]      wb_data,
    input  logic             flush,
    output logic             regf_we,
    output logic [4:0]       rd_s,
    output logic [31:0]      rd_v,
    output logic [TAG_W-1:0] commit_tag,
    output logic             commit,
    output logic [TAG_W:0]   count
);

    localparam logic [TAG_W:0] CountFull = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic allocFire;
    logic wbHit;

    // Readiness uses registered occupancy only, so a same-cycle commit never frees a slot early.
    assign alloc_ready = (count_q != CountFull);
    assign allocFire   = alloc_valid && alloc_ready;
    assign wbHit       = wb_valid && valid_q[wb_tag];

    assign commit     = valid_q[head_q] && done_q[head_q];
    assign regf_we    = commit && (rd_q[head_q] != 5'd0);
    assign rd_s       = commit ? rd_q[head_q] : 5'd0;
    assign rd_v       = commit ? data_q[head_q] : 32'd0;
    assign alloc_tag  = tail_q;
    assign commit_tag = head_q;
    assign count      = count_q;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (commit) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + TAG_W'(1);
            end
            if (wbHit) begin
                done_d[wb_tag] = 1'b1;
            end
            if (allocFire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                tail_d          = tail_q + TAG_W'(1);
            end
            count_d = count_q + (TAG_W+1)'(allocFire) - (TAG_W+1)'(commit);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset; it is only observed through a valid, done entry.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            if (allocFire) begin
                rd_q[tail_q] <= alloc_rd_s;
            end
            if (wbHit) begin
                data_q[wb_tag] <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Randomized and directed bench for rob_commit, checked against a program-order queue model.
module tb_rob_commit;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;

    logic             clk;
    logic             rst_n;
    logic             alloc_valid;
    logic [4:0]       alloc_rd_s;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             flush;
    logic             regf_we;
    logic [4:0]       rd_s;
    logic [31:0]      rd_v;
    logic [TAG_W-1:0] commit_tag;
    logic             commit;
    logic [TAG_W:0]   count;

    rob_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_rd_s(alloc_rd_s),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .flush(flush),
        .regf_we(regf_we), .rd_s(rd_s), .rd_v(rd_v),
        .commit_tag(commit_tag), .commit(commit), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int rd;
        bit done;
        int data;
    } entry_t;

    entry_t robQ[$];
    int mHead;
    int mTail;

    int checks;
    int failures;

    logic           obsCommit;
    logic           obsWe;
    logic [4:0]     obsRdS;
    logic [31:0]    obsRdV;
    logic           obsReady;
    logic [TAG_W-1:0] obsAllocTag;
    logic [TAG_W:0] obsCount;
    int             commitsSeen;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One cycle: drive at negedge, compare against the model, then advance the model past the edge.
    task automatic applyStimulus(input logic rstN, input logic av, input logic [4:0] ard,
                                 input logic wv, input logic [TAG_W-1:0] wt,
                                 input logic [31:0] wd, input logic fl);
        bit expCommit;
        int expRd;
        int expData;
        bit canAlloc;
        @(negedge clk);
        rst_n       = rstN;
        alloc_valid = av;
        alloc_rd_s  = ard;
        wb_valid    = wv;
        wb_tag      = wt;
        wb_data     = wd;
        flush       = fl;
        #1;
        expCommit = (robQ.size() > 0) && robQ[0].done;
        expRd     = expCommit ? robQ[0].rd : 0;
        expData   = expCommit ? robQ[0].data : 0;
        checkOutput("commit", 32'(commit), 32'(expCommit));
        checkOutput("regf_we", 32'(regf_we), 32'(expCommit && expRd != 0));
        checkOutput("rd_s", 32'(rd_s), 32'(expRd));
        checkOutput("rd_v", rd_v, 32'(expData));
        checkOutput("alloc_ready", 32'(alloc_ready), 32'(robQ.size() < DEPTH));
        checkOutput("alloc_tag", 32'(alloc_tag), 32'(mTail));
        checkOutput("commit_tag", 32'(commit_tag), 32'(mHead));
        checkOutput("count", 32'(count), 32'(robQ.size()));
        obsCommit   = commit;
        obsWe       = regf_we;
        obsRdS      = rd_s;
        obsRdV      = rd_v;
        obsReady    = alloc_ready;
        obsAllocTag = alloc_tag;
        obsCount    = count;
        if (commit) commitsSeen++;

        if (!rstN || fl) begin
            robQ.delete();
            mHead = 0;
            mTail = 0;
        end else begin
            canAlloc = robQ.size() < DEPTH;
            if (wv) begin
                foreach (robQ[i]) begin
                    if (robQ[i].tag == int'(wt)) begin
                        robQ[i].done = 1'b1;
                        robQ[i].data = int'(wd);
                    end
                end
            end
            if (expCommit) begin
                void'(robQ.pop_front());
                mHead = (mHead + 1) % DEPTH;
            end
            if (av && canAlloc) begin
                robQ.push_back('{tag: mTail, rd: int'(ard), done: 1'b0, data: 0});
                mTail = (mTail + 1) % DEPTH;
            end
        end
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, '0, 32'd0, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'($urandom), 5'($urandom), 1'($urandom), 3'($urandom), $urandom, 1'($urandom));
    endtask

    initial begin
        int allocated;
        int startCommits;
        checks      = 0;
        failures    = 0;
        commitsSeen = 0;
        mHead       = 0;
        mTail       = 0;
        rst_n       = 1'b0;
        alloc_valid = 1'b0;
        alloc_rd_s  = '0;
        wb_valid    = 1'b0;
        wb_tag      = '0;
        wb_data     = '0;
        flush       = 1'b0;

        // Reset held two cycles with random inputs, then post-reset outputs
        doReset();
        doReset();
        idle();
        checkOutput("rst_count", 32'(obsCount), 32'd0);
        checkOutput("rst_ready", 32'(obsReady), 32'd1);
        checkOutput("rst_we", 32'(obsWe), 32'd0);
        checkOutput("rst_rd_v", obsRdV, 32'd0);

        // Out-of-order writebacks retire in order
        applyStimulus(1'b1, 1'b1, 5'd1, 1'b0, '0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd2, 1'b0, '0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, '0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 3'd2, 32'h33, 1'b0);
        checkOutput("ooo_nocommit_a", 32'(obsCommit), 32'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 3'd0, 32'h11, 1'b0);
        checkOutput("ooo_nocommit_b", 32'(obsCommit), 32'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 3'd1, 32'h22, 1'b0);
        checkOutput("ooo_c1_rd", 32'(obsRdS), 32'd1);
        checkOutput("ooo_c1_v", obsRdV, 32'h11);
        idle();
        checkOutput("ooo_c2_rd", 32'(obsRdS), 32'd2);
        checkOutput("ooo_c2_v", obsRdV, 32'h22);
        idle();
        checkOutput("ooo_c3_rd", 32'(obsRdS), 32'd3);
        checkOutput("ooo_c3_v", obsRdV, 32'h33);
        idle();
        checkOutput("ooo_drained", 32'(obsCommit), 32'd0);

        // Full, refused allocation during the commit cycle, wrap across 20 entries
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, '0, 32'd0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(i + 1), 1'b0, '0, 32'd0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 5'd9, 1'b1, 3'd0, 32'hA0, 1'b0);
        checkOutput("full_ready", 32'(obsReady), 32'd0);
        checkOutput("full_count", 32'(obsCount), 32'd8);
        startCommits = commitsSeen;
        applyStimulus(1'b1, 1'b1, 5'd9, 1'b0, '0, 32'd0, 1'b0);
        checkOutput("full_commit", 32'(obsCommit), 32'd1);
        checkOutput("full_refused", 32'(obsReady), 32'd0);
        applyStimulus(1'b1, 1'b1, 5'd9, 1'b0, '0, 32'd0, 1'b0);
        checkOutput("wrap_ready", 32'(obsReady), 32'd1);
        checkOutput("wrap_tag", 32'(obsAllocTag), 32'd0);
        allocated = 9;
        for (int cyc = 0; cyc < 60 && robQ.size() > 0; cyc++) begin
            applyStimulus(1'b1, 1'(allocated < 20), 5'((allocated % 31) + 1), 1'b1,
                          3'(robQ[0].tag), 32'(32'h100 + cyc), 1'b0);
            if (allocated < 20 && obsReady) allocated++;
        end
        idle();
        checkOutput("wrap_commits", 32'(commitsSeen - startCommits), 32'd20);
        checkOutput("wrap_empty", 32'(obsCount), 32'd0);

        // x0 destination commits without a register write
        applyStimulus(1'b1, 1'b1, 5'd0, 1'b0, '0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 3'(robQ[0].tag), 32'hDEAD, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, '0, 32'd0, 1'b0);
        checkOutput("x0_commit", 32'(obsCommit), 32'd1);
        checkOutput("x0_we", 32'(obsWe), 32'd0);
        checkOutput("x0_count_before", 32'(obsCount), 32'd1);
        idle();
        checkOutput("x0_count_after", 32'(obsCount), 32'd0);

        // Flush with head done and a simultaneous allocation
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(20 + i), 1'b0, '0, 32'd0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 3'(robQ[0].tag), 32'h55, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd7, 1'b0, '0, 32'd0, 1'b1);
        checkOutput("flush_commit", 32'(obsCommit), 32'd1);
        checkOutput("flush_we", 32'(obsWe), 32'd1);
        idle();
        checkOutput("flush_count", 32'(obsCount), 32'd0);
        checkOutput("flush_tag", 32'(obsAllocTag), 32'd0);
        for (int t = 0; t < 8; t++) begin
            applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 3'(t), 32'h77, 1'b0);
        end
        idle();
        checkOutput("flush_stale_wb", 32'(obsCommit), 32'd0);

        // Stray writeback to an empty tag, then reset with done entries behind the head
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 3'd5, 32'h99, 1'b0);
        idle();
        checkOutput("stray_count", 32'(obsCount), 32'd0);
        checkOutput("stray_commit", 32'(obsCommit), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(i + 1), 1'b0, '0, 32'd0, 1'b0);
        end
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 3'(i), 32'(i), 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 3'd0, 32'h1, 1'b0);
        checkOutput("rst_mid_edge", 32'(obsCommit), 32'd0);
        idle();
        checkOutput("rst_mid_after", 32'(obsCommit), 32'd0);
        checkOutput("rst_mid_count", 32'(obsCount), 32'd0);
        idle();
        checkOutput("rst_mid_after2", 32'(obsCommit), 32'd0);

        // Randomized traffic with occasional flush and reset
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [TAG_W-1:0] wt;
            logic [4:0] ard;
            if (robQ.size() > 0 && $urandom_range(0, 3) != 0)
                wt = 3'(robQ[$urandom_range(0, robQ.size() - 1)].tag);
            else
                wt = 3'($urandom);
            ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            applyStimulus(1'($urandom_range(0, 149) != 0), 1'($urandom_range(0, 2) != 0), ard,
                          1'($urandom_range(0, 1)), wt, $urandom, 1'($urandom_range(0, 79) == 0));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
